// File: rtl/wb_pkg.sv
// Shared types for the write-back commit stage: byte-count encodings, drain states,
// the store-queue entry layout at default widths, and the last-byte helper.
package wb_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADR_W  = 16;

    typedef enum logic [1:0] {
        ONE   = 2'd0,
        TWO   = 2'd1,
        THREE = 2'd2
    } wb_cnt_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [WB_ADR_W-1:0]       adr;
        logic [2:0][WB_DATA_W-1:0] bytes;
        logic [1:0]                cnt;
        logic                      dec;
    } wb_entry_t;

    // Encoding 3 is illegal on the bus and is handled as a 3-byte write.
    function automatic logic [1:0] last_idx(input logic [1:0] cnt);
        return (cnt == 2'd3) ? 2'(THREE) : cnt;
    endfunction

endpackage

// File: rtl/wb_store_queue.sv
// Store-queue FIFO with wrap-bit pointers; push is ignored when full,
// pop is ignored when empty. Head is a combinational read of the storage.
module wb_store_queue #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW:0]      count_o
);

    logic [PW:0]                 wr_q, rd_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_q <= wr_q + (PW+1)'(1);
            if (pop_i && !empty_o)
                rd_q <= rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o)
            mem_q[wr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back stage: commits A/X/Y loads and queues 1-3 byte stores that drain one byte
// per memory handshake. Define WB_BYPASS_EN to forward committing loads onto a_o/x_o/y_o.
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADR_W    = 16,
    parameter int SQ_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                gbl_stl_i,
    input  logic                wait_to_fill_pipe_i,
    input  logic                wb_vld_i,
    input  logic                ra_ld_i,
    input  logic                rx_ld_i,
    input  logic                ry_ld_i,
    input  logic                mem_wr_i,
    input  logic [1:0]          mem_wr_cnt_i,
    input  logic                adr_dec_i,
    input  logic [DATA_W-1:0]   p_i,
    input  logic [2*DATA_W-1:0] dat_i,
    input  logic [ADR_W-1:0]    eff_adr_i,
    input  logic                mem_w_rdy_i,
    output logic [DATA_W-1:0]   a_o,
    output logic [DATA_W-1:0]   x_o,
    output logic [DATA_W-1:0]   y_o,
    output logic                wb_stl_o,
    output logic                sq_empty_o,
    output logic                mem_w_enb_o,
    output logic [ADR_W-1:0]    mem_w_adr_o,
    output logic [DATA_W-1:0]   mem_w_dat_o
);

    localparam int PW = $clog2(SQ_DEPTH);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADR_W-1:0]       adr;
        logic [2:0][DATA_W-1:0] bytes;
        logic [1:0]             cnt;
        logic                   dec;
    } entry_t;

    logic [DATA_W-1:0] a_q, x_q, y_q;
    wb_state_e         state_q;
    logic [1:0]        k_q;

    logic              full, empty, commit, push, pop, send;
    logic [PW:0]       count;
    logic [1:0]        last;
    logic [ADR_W-1:0]  byte_adr;
    entry_t            push_ent, head;

    assign commit   = wb_vld_i & ~gbl_stl_i & ~wait_to_fill_pipe_i & ~(mem_wr_i & full);
    assign push     = commit & mem_wr_i;
    assign wb_stl_o = wb_vld_i & mem_wr_i & full & ~gbl_stl_i & ~wait_to_fill_pipe_i;

    always_comb begin
        push_ent          = '0;
        push_ent.adr      = eff_adr_i;
        push_ent.bytes[0] = dat_i[DATA_W-1:0];
        push_ent.bytes[1] = dat_i[2*DATA_W-1:DATA_W];
        push_ent.bytes[2] = p_i;
        push_ent.cnt      = mem_wr_cnt_i;
        push_ent.dec      = adr_dec_i;
    end

    wb_store_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ent),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (commit) begin
            if (ra_ld_i) a_q <= dat_i[DATA_W-1:0];
            if (rx_ld_i) x_q <= dat_i[DATA_W-1:0];
            if (ry_ld_i) y_q <= dat_i[DATA_W-1:0];
        end
    end

`ifdef WB_BYPASS_EN
    assign a_o = (commit && ra_ld_i) ? dat_i[DATA_W-1:0] : a_q;
    assign x_o = (commit && rx_ld_i) ? dat_i[DATA_W-1:0] : x_q;
    assign y_o = (commit && ry_ld_i) ? dat_i[DATA_W-1:0] : y_q;
`else
    assign a_o = a_q;
    assign x_o = x_q;
    assign y_o = y_q;
`endif

    assign send = (state_q == SEND);
    assign last = last_idx(head.cnt);
    assign pop  = send & mem_w_rdy_i & (k_q == last);

    // Entering SEND on the push itself lets byte 0 appear the cycle after the commit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    k_q <= 2'd0;
                    if (push || !empty)
                        state_q <= SEND;
                end
                SEND: begin
                    if (mem_w_rdy_i) begin
                        if (k_q != last) begin
                            k_q <= k_q + 2'd1;
                        end else begin
                            k_q <= 2'd0;
                            if (count <= (PW+1)'(1) && !push)
                                state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= 2'd0;
                end
            endcase
        end
    end

    assign byte_adr    = head.dec ? head.adr - ADR_W'(k_q) : head.adr + ADR_W'(k_q);
    assign mem_w_enb_o = send;
    assign mem_w_adr_o = send ? byte_adr : '0;
    assign mem_w_dat_o = send ? head.bytes[k_q] : '0;
    assign sq_empty_o  = empty & ~send;

endmodule
